// File: rtl/line_fill_master_pkg.sv
// line_fill_master_pkg: AHB-Lite encodings and refill FSM states shared by the line fill engine.
package line_fill_master_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } trans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } burst_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;
    localparam logic [2:0] LAST_BEAT  = 3'd3;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_BURST,
        FILL_DONE,
        FILL_ERR
    } fill_state_t;

endpackage

// File: rtl/line_fill_master_wrap4_addr_gen.sv
// wrap4_addr_gen: address of beat n of a WRAP4 word burst, wrapping inside the 16-byte line.
module wrap4_addr_gen #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-5:0] line_i,
    input  logic [1:0]        crit_i,
    input  logic [1:0]        beat_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [1:0] word;

    assign word   = crit_i + beat_i;
    assign addr_o = {line_i, word, 2'b00};

endmodule

// File: rtl/line_fill_master.sv
// line_fill_master: I-cache refill engine issuing a critical-word-first AHB WRAP4 read burst.
module line_fill_master
    import line_fill_master_pkg::*;
#(
    parameter int CACHE_LINE = 128,
    parameter int ADDR_W     = 32
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  req_valid,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  req_ready,
    output logic                  crit_valid,
    output logic [31:0]           crit_data,
    output logic                  fill_valid,
    output logic [CACHE_LINE-1:0] fill_line,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic                  fill_err,
    output logic [ADDR_W-1:0]     haddr,
    output logic [1:0]            htrans,
    output logic [2:0]            hburst,
    output logic [2:0]            hsize,
    output logic                  hwrite,
    input  logic                  hready,
    input  logic [31:0]           hrdata,
    input  logic                  hresp
);

    fill_state_t           state_q;
    trans_t                htrans_q;
    burst_t                hburst_q;
    logic                  req_ready_q;
    logic                  crit_valid_q;
    logic                  fill_valid_q;
    logic                  fill_err_q;
    logic [31:0]           crit_data_q;
    logic [CACHE_LINE-1:0] fill_line_q;
    logic [ADDR_W-1:0]     fill_addr_q;
    logic [ADDR_W-1:0]     haddr_q;
    logic [ADDR_W-5:0]     line_q;
    logic [1:0]            crit_q;
    logic [2:0]            addr_cnt_q;
    logic [2:0]            data_cnt_q;

    logic                  idle;
    logic                  data_pend;
    logic                  addr_acc;
    logic                  data_acc;
    logic                  err_first;
    logic [1:0]            slot;
    logic [ADDR_W-5:0]     gen_line;
    logic [1:0]            gen_crit;
    logic [1:0]            gen_beat;
    logic [ADDR_W-1:0]     gen_addr;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    // A data phase is outstanding whenever more addresses were accepted than beats captured.
    assign idle      = state_q == FILL_IDLE;
    assign data_pend = data_cnt_q < addr_cnt_q;
    assign addr_acc  = htrans_q != HTRANS_IDLE && hready;
    assign data_acc  = state_q == FILL_BURST && data_pend && hready;
    assign err_first = state_q == FILL_BURST && data_pend && hresp && !hready;
    assign slot      = crit_q + data_cnt_q[1:0];

    // One generator serves both the first beat (from the request) and the following beats.
    assign gen_line = idle ? req_addr[ADDR_W-1:4] : line_q;
    assign gen_crit = idle ? req_addr[3:2] : crit_q;
    assign gen_beat = idle ? 2'd0 : addr_cnt_q[1:0] + 2'd1;

    wrap4_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .line_i (gen_line),
        .crit_i (gen_crit),
        .beat_i (gen_beat),
        .addr_o (gen_addr)
    );

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q      <= FILL_IDLE;
            htrans_q     <= HTRANS_IDLE;
            hburst_q     <= HBURST_SINGLE;
            req_ready_q  <= 1'b1;
            crit_valid_q <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            crit_data_q  <= '0;
            fill_line_q  <= '0;
            fill_addr_q  <= '0;
            haddr_q      <= '0;
            line_q       <= '0;
            crit_q       <= '0;
            addr_cnt_q   <= '0;
            data_cnt_q   <= '0;
        end else begin
            crit_valid_q <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            case (state_q)
                FILL_IDLE: if (req_valid) begin
                    state_q     <= FILL_BURST;
                    req_ready_q <= 1'b0;
                    line_q      <= req_addr[ADDR_W-1:4];
                    crit_q      <= req_addr[3:2];
                    fill_addr_q <= {req_addr[ADDR_W-1:4], 4'b0000};
                    haddr_q     <= gen_addr;
                    htrans_q    <= HTRANS_NONSEQ;
                    hburst_q    <= HBURST_WRAP4;
                    addr_cnt_q  <= '0;
                    data_cnt_q  <= '0;
                end
                FILL_BURST: begin
                    if (addr_acc) begin
                        addr_cnt_q <= addr_cnt_q + 3'd1;
                        haddr_q    <= addr_cnt_q == LAST_BEAT ? haddr_q : gen_addr;
                        htrans_q   <= addr_cnt_q == LAST_BEAT ? HTRANS_IDLE : HTRANS_SEQ;
                        hburst_q   <= addr_cnt_q == LAST_BEAT ? HBURST_SINGLE : HBURST_WRAP4;
                    end
                    if (data_acc) begin
                        fill_line_q[{slot, 5'd0} +: 32] <= hrdata;
                        data_cnt_q                      <= data_cnt_q + 3'd1;
                        crit_data_q                     <= data_cnt_q == 3'd0 ? hrdata : crit_data_q;
                        crit_valid_q                    <= data_cnt_q == 3'd0;
                        fill_valid_q                    <= data_cnt_q == LAST_BEAT;
                        state_q                         <= data_cnt_q == LAST_BEAT ? FILL_DONE : FILL_BURST;
                    end
                    if (err_first) begin
                        state_q  <= FILL_ERR;
                        htrans_q <= HTRANS_IDLE;
                        hburst_q <= HBURST_SINGLE;
                    end
                end
                FILL_DONE: begin
                    state_q     <= FILL_IDLE;
                    req_ready_q <= 1'b1;
                end
                FILL_ERR: if (hready) begin
                    state_q     <= FILL_IDLE;
                    req_ready_q <= 1'b1;
                    fill_err_q  <= 1'b1;
                end
                default: state_q <= FILL_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;
    assign fill_valid = fill_valid_q;
    assign fill_line  = fill_line_q;
    assign fill_addr  = fill_addr_q;
    assign fill_err   = fill_err_q;
    assign haddr      = haddr_q;
    assign htrans     = htrans_q;
    assign hburst     = hburst_q;
    assign hsize      = HSIZE_WORD;
    assign hwrite     = 1'b0;

endmodule

// File: tb/tb_line_fill_master.sv
// tb_line_fill_master: directed checks of the refill engine against a hand-driven AHB slave.
module tb_line_fill_master;

    logic         hclk = 1'b0;
    logic         hrst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [31:0]  fill_addr;
    logic         fill_err;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [2:0]   hsize;
    logic         hwrite;
    logic         hready;
    logic [31:0]  hrdata;
    logic         hresp;

    int n_cmp = 0;
    int n_bad = 0;
    int nseq;

    line_fill_master dut (
        .hclk       (hclk),
        .hrst       (hrst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .fill_valid (fill_valid),
        .fill_line  (fill_line),
        .fill_addr  (fill_addr),
        .fill_err   (fill_err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hburst     (hburst),
        .hsize      (hsize),
        .hwrite     (hwrite),
        .hready     (hready),
        .hrdata     (hrdata),
        .hresp      (hresp)
    );

    always #5 hclk = ~hclk;

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        hrst = 1'b1; req_valid = 1'b0; req_addr = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        repeat (2) tick;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_htrans", htrans, 2'b00);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hburst", hburst, 3'b000);
        chk("rst_hsize", hsize, 3'b010);
        chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_outs", {crit_valid, fill_valid, fill_err}, 3'b000);
        chk("rst_fill_line", fill_line, 128'h0);
        chk("rst_fill_addr", fill_addr, 32'h0);
        chk("rst_crit_data", crit_data, 32'h0);
        hrst = 1'b0;
        // 1: zero-wait burst, critical word 2
        req_valid = 1'b1; req_addr = 32'h0000_1008;
        tick;
        req_valid = 1'b0;
        chk("t1_nonseq", htrans, 2'b10);
        chk("t1_addr0", haddr, 32'h1008);
        chk("t1_hburst", hburst, 3'b010);
        chk("t1_busy", req_ready, 1'b0);
        tick;
        chk("t1_seq1", htrans, 2'b11);
        chk("t1_addr1", haddr, 32'h100C);
        hrdata = 32'hA0;
        tick;
        chk("t1_crit_valid", crit_valid, 1'b1);
        chk("t1_crit_data", crit_data, 32'hA0);
        chk("t1_addr2", haddr, 32'h1000);
        hrdata = 32'hA1;
        tick;
        chk("t1_addr3", haddr, 32'h1004);
        chk("t1_crit_pulse", crit_valid, 1'b0);
        hrdata = 32'hA2;
        tick;
        chk("t1_idle_after4", htrans, 2'b00);
        chk("t1_no_early_fill", fill_valid, 1'b0);
        hrdata = 32'hA3;
        tick;
        chk("t1_fill_valid", fill_valid, 1'b1);
        chk("t1_fill_line", fill_line, 128'h000000A1_000000A0_000000A3_000000A2);
        chk("t1_fill_addr", fill_addr, 32'h1000);
        chk("t1_no_crit", crit_valid, 1'b0);
        tick;
        chk("t1_fill_pulse", fill_valid, 1'b0);
        chk("t1_ready", req_ready, 1'b1);
        // 2: two wait states on beat 1, critical word 3 wraps
        req_valid = 1'b1; req_addr = 32'h2000_000C;
        tick;
        req_valid = 1'b0;
        chk("t2_addr0", haddr, 32'h2000_000C);
        tick;
        chk("t2_addr1", haddr, 32'h2000_0000);
        hrdata = 32'hB0;
        tick;
        chk("t2_crit_data", crit_data, 32'hB0);
        chk("t2_addr2", haddr, 32'h2000_0004);
        hready = 1'b0;
        tick;
        chk("t2_hold_addr", haddr, 32'h2000_0004);
        chk("t2_hold_trans", htrans, 2'b11);
        tick;
        hready = 1'b1; hrdata = 32'hB1;
        tick;
        chk("t2_addr3", haddr, 32'h2000_0008);
        hrdata = 32'hB2;
        tick;
        chk("t2_idle", htrans, 2'b00);
        chk("t2_no_early_fill", fill_valid, 1'b0);
        hrdata = 32'hB3;
        tick;
        chk("t2_fill_valid", fill_valid, 1'b1);
        chk("t2_fill_line", fill_line, 128'h000000B0_000000B3_000000B2_000000B1);
        chk("t2_fill_addr", fill_addr, 32'h2000_0000);
        tick;
        chk("t2_ready", req_ready, 1'b1);
        // 3: ERROR response on beat 2
        req_valid = 1'b1; req_addr = 32'h3000_0000;
        tick;
        req_valid = 1'b0;
        tick;
        hrdata = 32'hC0;
        tick;
        hrdata = 32'hC1;
        tick;
        hresp = 1'b1; hready = 1'b0;
        tick;
        chk("t3_idle_next", htrans, 2'b00);
        chk("t3_no_err_yet", fill_err, 1'b0);
        hready = 1'b1;
        tick;
        hresp = 1'b0;
        chk("t3_fill_err", fill_err, 1'b1);
        chk("t3_no_fill", fill_valid, 1'b0);
        chk("t3_ready", req_ready, 1'b1);
        tick;
        chk("t3_err_pulse", fill_err, 1'b0);
        chk("t3_no_fill_late", fill_valid, 1'b0);
        // 4: request held high through a burst is taken once, then again at req_ready
        req_valid = 1'b1; req_addr = 32'h4000_0004;
        tick;
        nseq = 0;
        for (int i = 0; i < 7; i++) begin
            if (htrans == 2'b10) nseq++;
            tick;
        end
        chk("t4_single_burst", nseq, 1);
        chk("t4_second_accept", htrans, 2'b10);
        chk("t4_second_addr", haddr, 32'h4000_0004);
        req_valid = 1'b0;
        repeat (6) tick;
        chk("t4_ready", req_ready, 1'b1);
        // 6: back-to-back 0x0 then 0x10
        req_valid = 1'b1; req_addr = 32'h0;
        tick;
        repeat (5) tick;
        chk("t6_fill_valid0", fill_valid, 1'b1);
        chk("t6_fill_addr0", fill_addr, 32'h0);
        req_addr = 32'h10;
        tick;
        chk("t6_gap_idle", htrans, 2'b00);
        chk("t6_gap_ready", req_ready, 1'b1);
        tick;
        chk("t6_nonseq2", htrans, 2'b10);
        chk("t6_addr2", haddr, 32'h10);
        req_valid = 1'b0;
        repeat (5) tick;
        chk("t6_fill_valid1", fill_valid, 1'b1);
        chk("t6_fill_addr1", fill_addr, 32'h10);
        tick;
        // 5: reset in the middle of a burst
        req_valid = 1'b1; req_addr = 32'h5000_0008;
        tick;
        req_valid = 1'b0;
        tick;
        hrdata = 32'hD0;
        tick;
        chk("t5_crit_before_rst", crit_valid, 1'b1);
        hrst = 1'b1;
        tick;
        hrst = 1'b0;
        chk("t5_htrans", htrans, 2'b00);
        chk("t5_haddr", haddr, 32'h0);
        chk("t5_hburst", hburst, 3'b000);
        chk("t5_ready", req_ready, 1'b1);
        chk("t5_pulses", {crit_valid, fill_valid, fill_err}, 3'b000);
        chk("t5_crit_data", crit_data, 32'h0);
        chk("t5_fill_line", fill_line, 128'h0);
        chk("t5_fill_addr", fill_addr, 32'h0);
        tick;
        chk("t5_stay_idle", htrans, 2'b00);
        chk("t5_no_fill", {fill_valid, fill_err}, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
